cdb_arbiter: RTL
================

# cdb_arbiter

Arbiter and scheduler for the common data bus (CDB): the single result-broadcast channel is shared between the ALU reservation station and the load/store buffer. Each source pushes completed results into its own small FIFO, and the arbiter pops at most one entry per cycle in round-robin order. The popped entry goes onto a registered CDB that feeds the ROB, the RS and the LSB. A ROB clear (mispredict) empties all pending results.

## Interface
- `ROB_TAG_W`, default 4: width of the ROB tag carried with each result.
- `DATA_W`, default 32: result value width.
- `DEPTH`, default 2: entries per source FIFO. Must be a power of two and ≥2.

Ports:
- `clk` input 1: the only clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset asserted).
- `rdy` input 1: global enable; while 0, no state changes.
- `clear` input 1: ROB flush; synchronous; drops all buffered and in-flight results.
- `alu_valid` input 1: ALU result present this cycle.
- `alu_tag` input ROB_TAG_W: ROB tag of the ALU result.
- `alu_value` input DATA_W: ALU result value.
- `alu_ready` output 1: ALU FIFO can accept a push this cycle.
- `lsb_valid`, `lsb_tag`, `lsb_value`, `lsb_ready`: same four signals for the LSB source.
- `cdb_valid` output 1: broadcast valid, asserted for exactly one cycle per result.
- `cdb_tag` output ROB_TAG_W: broadcast ROB tag.
- `cdb_value` output DATA_W: broadcast value.
- `cdb_src` output 1: source of the broadcast; 0 = ALU, 1 = LSB.

## Operation
- Per-source FIFO state: head pointer, tail pointer and count (width log2(DEPTH)+1).
- `x_ready = rdy & (count_x != DEPTH)`, decoded combinationally from registered count.
- `x_ready` does not account for a same-cycle pop; this is deliberate and conservative.
- Push: on an edge with `x_valid & x_ready & rdy & ~clear`, write {tag, value} at the tail and advance the tail modulo DEPTH.
- A push with `x_ready = 0` is ignored. The producer must hold the result, and the bench flags this case as a protocol error.
- Arbitration each cycle (`rdy` = 1, `clear` = 0), using FIFO state at the start of the cycle:
  - Neither FIFO has entries: no grant; `cdb_valid` is 0 next cycle.
  - Exactly one FIFO has entries: that source is granted.
  - Both have entries: the source not recorded in `last_grant` is granted.
- On a grant: pop the head, register {tag, value, src} into the CDB outputs, set `cdb_valid` = 1, and set `last_grant` to the granted source.
- Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance.
- `clear` (with `rdy` = 1):
  - All pointers and counts go to 0.
  - `cdb_valid` goes to 0 on the next edge.
  - A same-cycle push is dropped.
  - `last_grant` is kept.
- `clear` has priority over push, pop and arbitration.
- `rdy` = 0: FIFOs, `last_grant` and CDB output registers hold. `cdb_valid` holds its value, so the consumers' `rdy` gating applies.
- `cdb_tag`, `cdb_value` and `cdb_src` hold their last values when `cdb_valid` = 0.

## Timing
- Reset (`rst` = 0, asynchronous):
  - `cdb_valid`, `cdb_tag`, `cdb_value` and `cdb_src` go to 0.
  - All counts and pointers go to 0, so `alu_ready` = `lsb_ready` = `rdy`.
  - `last_grant` = 1 (LSB), so the ALU wins the first tie.
- Reset release mid-traffic: the first accepted push is on the first rising edge with `rst` = 1.
- Latency: a push accepted at edge t can broadcast at the earliest at edge t+1, visible in the cycle after t+1. There is no input-to-CDB bypass.
- Throughput: one broadcast per cycle total. With a single active source, one push and one pop per cycle sustain full rate with DEPTH = 2.
- Fairness: with both sources continuously backlogged, grants strictly alternate, and each source waits at most 1 cycle behind the other.
- Pointer wrap-around: modulo DEPTH, with no bubble at wrap.
- `rst` asserted mid-operation discards all pending results immediately.

## Test plan
- Reset, then ALU pushes {tag 3, 0x11} at edge 1 -> `cdb_valid` = 1 with tag 3, value 0x11, src 0 after edge 2; `cdb_valid` = 0 after edge 3.
- ALU and LSB each push 4 results back to back while respecting ready -> CDB order is ALU, LSB, ALU, LSB, …; all 8 delivered; no duplicates or losses.
- Hold off arbitration by pushing only LSB while the ALU FIFO is filled to DEPTH -> `alu_ready` = 0; an extra `alu_valid` is ignored; the FIFO contents are unchanged.
- Two full FIFOs, then `clear` pulsed with a concurrent `alu_valid` -> next cycle all counts are 0, `cdb_valid` = 0, both readies = 1, and no later broadcast of pre-clear or same-cycle results.
- Hold `rdy` = 0 for 3 cycles with entries pending -> outputs and counts are frozen and the readies are 0; broadcasting resumes in round-robin order when `rdy` returns to 1.
- Stream 10 ALU results through DEPTH = 2 -> correct tag/value sequence across pointer wrap; `cdb_valid` is high every cycle once the stream is in steady state.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Result-broadcast bundle between the ALU/LSB producers, the CDB arbiter and the CDB consumers.
// Ports: alu_* and lsb_* producer handshakes (valid/tag/value in, ready out of the arbiter),
//        cdb_* registered broadcast (valid/tag/value/src) out of the arbiter.
interface cdb_arbiter_if #(
    parameter int ROB_TAG_W = 4,
    parameter int DATA_W    = 32
);
    logic                 alu_valid;
    logic [ROB_TAG_W-1:0] alu_tag;
    logic [DATA_W-1:0]    alu_value;
    logic                 alu_ready;

    logic                 lsb_valid;
    logic [ROB_TAG_W-1:0] lsb_tag;
    logic [DATA_W-1:0]    lsb_value;
    logic                 lsb_ready;

    logic                 cdb_valid;
    logic [ROB_TAG_W-1:0] cdb_tag;
    logic [DATA_W-1:0]    cdb_value;
    logic                 cdb_src;

    // Producer / observer side.
    modport master (
        output alu_valid, alu_tag, alu_value,
        input  alu_ready,
        output lsb_valid, lsb_tag, lsb_value,
        input  lsb_ready,
        input  cdb_valid, cdb_tag, cdb_value, cdb_src
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_tag, alu_value,
        output alu_ready,
        input  lsb_valid, lsb_tag, lsb_value,
        output lsb_ready,
        output cdb_valid, cdb_tag, cdb_value, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Purpose: per-source result FIFOs plus round-robin arbiter driving the registered common data bus.
// Latency: a push accepted at edge t can broadcast at edge t+1 at the earliest (no bypass).
// Backpressure: x_ready drops when the source FIFO is full or rdy=0; rdy=0 freezes all state.
// Ports: clk, rst (async active-low), rdy (global enable), clear (sync flush), bus (slave modport).

// Small FIFO: head/tail pointers plus occupancy count; storage is not reset.
module cdb_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_dat_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (en_i) begin
            if (clear_i) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                cnt_d    = '0;
            end else begin
                if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
                cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en_i && !clear_i && push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = cnt_q;
endmodule

module cdb_arbiter #(
    parameter int ROB_TAG_W = 4,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          clear,
    cdb_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ROB_TAG_W + DATA_W;

    logic [CNT_W-1:0] alu_cnt, lsb_cnt;
    logic [ENT_W-1:0] alu_head, lsb_head, sel_head;
    logic             alu_ready, lsb_ready;
    logic             alu_push, lsb_push, alu_pop, lsb_pop;
    logic             alu_has, lsb_has;
    logic             gnt_vld, gnt_src, gnt_go;

    logic                 cdb_valid_q, cdb_valid_d;
    logic [ROB_TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]    cdb_value_q, cdb_value_d;
    logic                 cdb_src_q, cdb_src_d;
    logic                 last_grant_q, last_grant_d;

    // Ready ignores a same-cycle pop on purpose: it depends only on registered count.
    assign alu_ready = rdy & (alu_cnt != CNT_W'(DEPTH));
    assign lsb_ready = rdy & (lsb_cnt != CNT_W'(DEPTH));
    assign alu_push  = bus.alu_valid & alu_ready & ~clear;
    assign lsb_push  = bus.lsb_valid & lsb_ready & ~clear;

    assign alu_has = (alu_cnt != '0);
    assign lsb_has = (lsb_cnt != '0);

    // LSB wins when it is alone, or on a tie when the ALU was granted last.
    assign gnt_vld  = alu_has | lsb_has;
    assign gnt_src  = lsb_has & (~alu_has | ~last_grant_q);
    assign gnt_go   = rdy & ~clear & gnt_vld;
    assign alu_pop  = gnt_go & ~gnt_src;
    assign lsb_pop  = gnt_go &  gnt_src;
    assign sel_head = gnt_src ? lsb_head : alu_head;

    cdb_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk        (clk),
        .rst        (rst),
        .en_i       (rdy),
        .clear_i    (clear),
        .push_i     (alu_push),
        .push_dat_i ({bus.alu_tag, bus.alu_value}),
        .pop_i      (alu_pop),
        .head_dat_o (alu_head),
        .count_o    (alu_cnt)
    );

    cdb_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_lsb_fifo (
        .clk        (clk),
        .rst        (rst),
        .en_i       (rdy),
        .clear_i    (clear),
        .push_i     (lsb_push),
        .push_dat_i ({bus.lsb_tag, bus.lsb_value}),
        .pop_i      (lsb_pop),
        .head_dat_o (lsb_head),
        .count_o    (lsb_cnt)
    );

    // Tag/value/src only change on a grant so they hold while cdb_valid is low.
    always_comb begin
        cdb_valid_d  = cdb_valid_q;
        cdb_tag_d    = cdb_tag_q;
        cdb_value_d  = cdb_value_q;
        cdb_src_d    = cdb_src_q;
        last_grant_d = last_grant_q;
        if (rdy) begin
            if (clear) begin
                cdb_valid_d = 1'b0;
            end else begin
                cdb_valid_d = gnt_vld;
                if (gnt_vld) begin
                    cdb_tag_d    = sel_head[ENT_W-1:DATA_W];
                    cdb_value_d  = sel_head[DATA_W-1:0];
                    cdb_src_d    = gnt_src;
                    last_grant_d = gnt_src;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_value_q  <= '0;
            cdb_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_value_q  <= cdb_value_d;
            cdb_src_q    <= cdb_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.alu_ready = alu_ready;
    assign bus.lsb_ready = lsb_ready;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_value = cdb_value_q;
    assign bus.cdb_src   = cdb_src_q;
endmodule
